// File: rtl/rs232_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_pkg
//  Description : Shared definitions for the 16x-oversampled RS232 transmitter
//                and receiver: state encoding, bit timing constants and the
//                2-of-3 majority helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs232_pkg;

    // Receiver / transmitter frame states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rs232_state_e;

    // Clock16x cycles per serial bit
    localparam int TICKS_PER_BIT = 16;

    // Tick at which a single-sample receiver looks at the line
    localparam logic [3:0] SAMPLE_TICK = 4'd7;

    // Tick at which the sampled bit value is acted upon
    localparam logic [3:0] COMMIT_TICK = 4'd8;

    // Final tick of a bit period; the counter wraps to 0 after it
    localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_BIT - 1);

    // 2-of-3 majority vote
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs232_sync.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_sync
//  Description : Multi-stage metastability synchronizer for an asynchronous
//                serial line. Resets to 1 so the line reads as idle.
//                SYNC_STAGES must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs232_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock16x,
    input  logic Reset,
    input  logic Din,
    output logic Dout
);

    logic [SYNC_STAGES-1:0] r_stages;

    // Shift the asynchronous input through the flop chain; idle-high reset
    always_ff @(posedge Clock16x) begin
        if (Reset) begin
            r_stages <= '1;
        end else begin
            r_stages <= {r_stages[SYNC_STAGES-2:0], Din};
        end
    end

    assign Dout = r_stages[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rs232_rxd.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_rxd
//  Description : RS232 8N1 asynchronous receiver, 16x oversampled on
//                Clock16x. Validates start and stop bits, delivers each good
//                byte on DataOut with a one-cycle DataValid strobe and flags
//                a low stop bit with a one-cycle FramingError strobe.
//                Optional build macro RS232_RXD_MAJORITY_EN: each bit is the
//                2-of-3 majority of ticks 6, 7, 8 instead of a single sample
//                at tick 7. Commit tick and latency are identical.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs232_rxd
    import rs232_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 Clock16x,
    input  logic                 Reset,
    input  logic                 Rxd,
    output logic [DATA_BITS-1:0] DataOut,
    output logic                 DataValid,
    output logic                 FramingError,
    output logic                 Busy
);

    localparam int BIT_CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    rs232_state_e           r_state;
    logic [3:0]             r_tick;
    logic [BIT_CNT_W-1:0]   r_bitCnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shiftNext;
    logic                   w_rxS;
    logic                   w_bitValue;

    rs232_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .Clock16x (Clock16x),
        .Reset    (Reset),
        .Din      (Rxd),
        .Dout     (w_rxS)
    );

`ifdef RS232_RXD_MAJORITY_EN
    localparam logic [3:0] EARLY_TICK = SAMPLE_TICK - 4'd1;

    logic r_s6;
    logic r_s7;

    // Capture the line at ticks 6 and 7; tick 8 is taken live at commit
    always_ff @(posedge Clock16x) begin
        if (Reset) begin
            r_s6 <= 1'b1;
            r_s7 <= 1'b1;
        end else begin
            if (r_tick == EARLY_TICK) begin
                r_s6 <= w_rxS;
            end
            if (r_tick == SAMPLE_TICK) begin
                r_s7 <= w_rxS;
            end
        end
    end

    assign w_bitValue = majority3(r_s6, r_s7, w_rxS);
`else
    logic r_s7;

    // Capture the line at tick 7; used one cycle later at commit
    always_ff @(posedge Clock16x) begin
        if (Reset) begin
            r_s7 <= 1'b1;
        end else if (r_tick == SAMPLE_TICK) begin
            r_s7 <= w_rxS;
        end
    end

    assign w_bitValue = r_s7;
`endif

    // Next shift register value: LSB-first, new bit enters at the MSB
    always_comb begin
        w_shiftNext                = r_shift >> 1;
        w_shiftNext[DATA_BITS-1]   = w_bitValue;
    end

    // Frame state machine with registered strobes and data output
    always_ff @(posedge Clock16x) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_tick       <= 4'd0;
            r_bitCnt     <= '0;
            r_shift      <= '0;
            DataOut      <= '0;
            DataValid    <= 1'b0;
            FramingError <= 1'b0;
        end else begin
            DataValid    <= 1'b0;
            FramingError <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_bitCnt <= '0;
                    // The cycle that first sees the line low is start tick 0
                    if (!w_rxS) begin
                        r_state <= START;
                        r_tick  <= 4'd1;
                    end else begin
                        r_tick  <= 4'd0;
                    end
                end

                START: begin
                    r_tick <= r_tick + 4'd1;
                    if ((r_tick == COMMIT_TICK) && w_bitValue) begin
                        // False start: line was high at mid-bit
                        r_state <= IDLE;
                        r_tick  <= 4'd0;
                    end else if (r_tick == LAST_TICK) begin
                        r_state  <= DATA;
                        r_bitCnt <= '0;
                    end
                end

                DATA: begin
                    r_tick <= r_tick + 4'd1;
                    if (r_tick == COMMIT_TICK) begin
                        r_shift <= w_shiftNext;
                    end
                    if (r_tick == LAST_TICK) begin
                        if (r_bitCnt == LAST_BIT) begin
                            r_state  <= STOP;
                            r_bitCnt <= '0;
                        end else begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                        end
                    end
                end

                STOP: begin
                    r_tick <= r_tick + 4'd1;
                    if (r_tick == COMMIT_TICK) begin
                        r_tick <= 4'd0;
                        if (w_bitValue) begin
                            // Good frame; leaving early allows back-to-back frames
                            DataOut   <= r_shift;
                            DataValid <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            FramingError <= 1'b1;
                            r_state      <= BREAK;
                        end
                    end
                end

                BREAK: begin
                    // Hold off until the line returns to idle so a held-low
                    // line produces only one error
                    r_tick <= 4'd0;
                    if (w_rxS) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_tick  <= 4'd0;
                end
            endcase
        end
    end

    assign Busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rs232_rxd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs232_rxd
//  Description : Self-checking bench for rs232_rxd. Table of whole frames
//                plus hand sequences for back-to-back frames, false start,
//                line break and reset mid-frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_rxd;

    logic       Clock16x = 1'b0;
    logic       Reset;
    logic       Rxd;
    logic [7:0] DataOut;
    logic       DataValid;
    logic       FramingError;
    logic       Busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    rs232_rxd #(
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .Clock16x     (Clock16x),
        .Reset        (Reset),
        .Rxd          (Rxd),
        .DataOut      (DataOut),
        .DataValid    (DataValid),
        .FramingError (FramingError),
        .Busy         (Busy)
    );

    always #5 Clock16x = ~Clock16x;

    always @(posedge Clock16x) cyc <= cyc + 1;

`ifdef RS232_RXD_MAJORITY_EN
    localparam logic [7:0] GLITCH_EXP = 8'h96;
`else
    localparam logic [7:0] GLITCH_EXP = 8'h69;
`endif

    // Pulse monitor: records every strobe with its cycle number
    int         dvCnt   = 0;
    int         feCnt   = 0;
    int         overlap = 0;
    int         wide    = 0;
    int         dvCycQ[$];
    logic [7:0] dvDataQ[$];
    int         feCycQ[$];
    logic       dvPrev  = 1'b0;
    logic       fePrev  = 1'b0;

    always @(negedge Clock16x) begin
        if (DataValid === 1'b1) begin
            dvCnt++;
            dvCycQ.push_back(cyc);
            dvDataQ.push_back(DataOut);
        end
        if (FramingError === 1'b1) begin
            feCnt++;
            feCycQ.push_back(cyc);
        end
        if (DataValid === 1'b1 && FramingError === 1'b1) overlap++;
        if ((DataValid === 1'b1 && dvPrev) || (FramingError === 1'b1 && fePrev)) wide++;
        dvPrev = (DataValid === 1'b1);
        fePrev = (FramingError === 1'b1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive nCyc cycles of a frame (160 = full frame), starting at a negedge
    task automatic send_frame(input logic [7:0] d, input logic stopv, input bit glitch,
                              input int nCyc, output int fall);
        logic [9:0] bits;
        int         b;
        int         t;
        bits = {stopv, d, 1'b0};
        fall = 0;
        for (int k = 0; k < nCyc; k++) begin
            b = k / 16;
            t = k % 16;
            @(negedge Clock16x);
            if (k == 0) fall = cyc;
            Rxd = bits[b] ^ (glitch && b >= 1 && b <= 8 && t == 7);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clock16x);
            Rxd = 1'b1;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stopv;
        bit         glitch;
        int         expDv;
        int         expFe;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int fall;
        int fall2;
        int dvB;
        int feB;
        int busyLow;
        logic busyMid;
        logic busyEnd;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 1, 0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 0, 1, 8'hFF};
        vecs[4] = '{8'h96, 1'b1, 1'b1, 1, 0, GLITCH_EXP};

        // Reset state
        Reset = 1'b1;
        Rxd   = 1'b1;
        repeat (4) @(negedge Clock16x);
        chk("reset_dataout", 32'(DataOut), 32'h0);
        chk("reset_valid",   32'(DataValid), 32'h0);
        chk("reset_fe",      32'(FramingError), 32'h0);
        chk("reset_busy",    32'(Busy), 32'h0);
        Reset = 1'b0;
        idle(10);

        // Table of whole frames
        for (int i = 0; i < 5; i++) begin
            dvB = dvCnt;
            feB = feCnt;
            send_frame(vecs[i].data, vecs[i].stopv, vecs[i].glitch, 160, fall);
            idle(30);
            #1;
            chk($sformatf("vec%0d_dv_count", i), 32'(dvCnt - dvB), 32'(vecs[i].expDv));
            chk($sformatf("vec%0d_fe_count", i), 32'(feCnt - feB), 32'(vecs[i].expFe));
            chk($sformatf("vec%0d_dataout", i), 32'(DataOut), 32'(vecs[i].expData));
            if (vecs[i].expDv == 1 && dvCnt > dvB) begin
                chk($sformatf("vec%0d_dv_latency", i), 32'(dvCycQ[dvB] - fall), 32'd155);
                chk($sformatf("vec%0d_dv_data", i), 32'(dvDataQ[dvB]), 32'(vecs[i].expData));
            end
            if (vecs[i].expFe == 1 && feCnt > feB) begin
                chk($sformatf("vec%0d_fe_latency", i), 32'(feCycQ[feB] - fall), 32'd155);
            end
        end

        // Back-to-back frames, no idle gap
        dvB = dvCnt;
        feB = feCnt;
        send_frame(8'h00, 1'b1, 1'b0, 160, fall);
        send_frame(8'hFF, 1'b1, 1'b0, 160, fall2);
        idle(30);
        #1;
        chk("b2b_dv_count", 32'(dvCnt - dvB), 32'd2);
        chk("b2b_fe_count", 32'(feCnt - feB), 32'd0);
        if (dvCnt >= dvB + 2) begin
            chk("b2b_first_data",  32'(dvDataQ[dvB]), 32'h00);
            chk("b2b_second_data", 32'(dvDataQ[dvB+1]), 32'hFF);
            chk("b2b_spacing",     32'(dvCycQ[dvB+1] - dvCycQ[dvB]), 32'd160);
        end

        // False start: 4 low cycles then high
        dvB = dvCnt;
        feB = feCnt;
        busyMid = 1'b0;
        busyEnd = 1'b1;
        @(negedge Clock16x);
        Rxd  = 1'b0;
        fall = cyc;
        for (int k = 1; k < 24; k++) begin
            @(negedge Clock16x);
            Rxd = (k < 4) ? 1'b0 : 1'b1;
            if (cyc == fall + 6)  busyMid = Busy;
            if (cyc == fall + 11) busyEnd = Busy;
        end
        idle(10);
        #1;
        chk("false_busy_high", 32'(busyMid), 32'd1);
        chk("false_busy_low",  32'(busyEnd), 32'd0);
        chk("false_dv_count",  32'(dvCnt - dvB), 32'd0);
        chk("false_fe_count",  32'(feCnt - feB), 32'd0);

        // Stop bit low then line held low (break)
        dvB = dvCnt;
        feB = feCnt;
        busyLow = 0;
        send_frame(8'h3C, 1'b0, 1'b0, 160, fall);
        repeat (500) begin
            @(negedge Clock16x);
            Rxd = 1'b0;
            if (Busy !== 1'b1) busyLow++;
        end
        idle(10);
        #1;
        chk("break_fe_count",  32'(feCnt - feB), 32'd1);
        chk("break_dv_count",  32'(dvCnt - dvB), 32'd0);
        if (feCnt > feB) chk("break_fe_latency", 32'(feCycQ[feB] - fall), 32'd155);
        chk("break_busy_held", 32'(busyLow), 32'd0);
        chk("break_busy_end",  32'(Busy), 32'd0);
        chk("break_dataout",   32'(DataOut), 32'hFF);

        // Reset for one cycle during data bit 4 of 0x55
        dvB = dvCnt;
        feB = feCnt;
        send_frame(8'h55, 1'b1, 1'b0, 88, fall);
        @(negedge Clock16x);
        Reset = 1'b1;
        Rxd   = 1'b1;
        @(negedge Clock16x);
        Reset = 1'b0;
        chk("rst_mid_dataout", 32'(DataOut), 32'h0);
        chk("rst_mid_valid",   32'(DataValid), 32'h0);
        chk("rst_mid_fe",      32'(FramingError), 32'h0);
        chk("rst_mid_busy",    32'(Busy), 32'h0);
        idle(30);
        #1;
        chk("rst_mid_no_dv", 32'(dvCnt - dvB), 32'd0);
        chk("rst_mid_no_fe", 32'(feCnt - feB), 32'd0);
        dvB = dvCnt;
        send_frame(8'h81, 1'b1, 1'b0, 160, fall);
        idle(30);
        #1;
        chk("after_rst_dv_count", 32'(dvCnt - dvB), 32'd1);
        chk("after_rst_dataout",  32'(DataOut), 32'h81);

        // Strobe hygiene over the whole run
        chk("dv_fe_overlap", 32'(overlap), 32'd0);
        chk("pulse_width",   32'(wide), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
